// File: rtl/sb_tx_rdi_encoder.sv
// sb_tx_rdi_encoder
//   Buffers RDI sideband message requests in a small FIFO and encodes each
//   one into a 64-bit message-without-data header, presented to the framer
//   under a valid/ack handshake. Illegal requests (code 3) are accepted,
//   dropped and flagged with a one-cycle error pulse.
//
// Parameters
//   SRCID       source ID, header [31:29]
//   DSTID       destination ID, header [58:56]
//   FIFO_DEPTH  request buffer depth (power of two, >= 2)
//
// Ports
//   i_clk               clock, rising edge
//   i_rst               asynchronous active-high reset
//   i_rdi_msg_valid     request valid
//   o_rdi_msg_ready     request may be accepted (FIFO not full, not in reset)
//   i_rdi_msg_code      0=Nop 1=Req 2=Resp 3=illegal
//   i_rdi_msg_sub_code  message subcode
//   i_rdi_msg_info      message info
//   o_rdi_header        encoded header (holds last value when idle)
//   o_rdi_header_valid  header awaiting acknowledge
//   i_rdi_header_ack    framer consumed the header
//   o_rdi_msg_err       pulse: illegal request discarded
//   o_rdi_busy          FIFO non-empty or header pending
module sb_tx_rdi_encoder #(
    parameter logic [2:0]  SRCID      = 3'b010,
    parameter logic [2:0]  DSTID      = 3'b110,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rdi_msg_valid,
    output logic        o_rdi_msg_ready,
    input  logic [1:0]  i_rdi_msg_code,
    input  logic [3:0]  i_rdi_msg_sub_code,
    input  logic [1:0]  i_rdi_msg_info,
    output logic [63:0] o_rdi_header,
    output logic        o_rdi_header_valid,
    input  logic        i_rdi_header_ack,
    output logic        o_rdi_msg_err,
    output logic        o_rdi_busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    // FIFO entry packing: {code[1:0], sub_code[3:0], info[1:0]}
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;

    logic          accept;
    logic          push;
    logic          pop;
    logic [63:0]   header;
    logic          msg_err;

    function automatic logic [63:0] encode(input logic [7:0] e);
        logic [63:0] h;
        logic [15:0] msg_info;
        case (e[7:6])
            2'd0:    msg_info = {14'b0, e[1:0]};
            2'd2:    msg_info = {15'b0, e[0]};
            default: msg_info = '0;
        endcase
        h        = '0;
        h[4:0]   = 5'b10010;
        h[21:14] = {6'b0, e[7:6]};
        h[31:29] = SRCID;
        h[39:32] = {4'b0, e[5:2]};
        h[55:40] = msg_info;
        h[58:56] = DSTID;
        // CP gives even parity over bits [62:0]; DP [63] stays 0
        h[62]    = ^h[61:0];
        return h;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

    // Gated by reset so ready is low throughout reset and rises in the
    // first cycle after release.
    assign o_rdi_msg_ready = ~i_rst & ~fifo_full;

    assign accept = i_rdi_msg_valid & o_rdi_msg_ready;
    assign push   = accept & (i_rdi_msg_code != 2'd3);

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and pop decision
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (i_rdi_header_ack) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_rdi_msg_code, i_rdi_msg_sub_code, i_rdi_msg_info};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            header  <= '0;
            msg_err <= 1'b0;
        end else begin
            msg_err <= accept & (i_rdi_msg_code == 2'd3);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                header <= encode(mem[rd_ptr]);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_rdi_header       = header;
    assign o_rdi_header_valid = (state == HOLD);
    assign o_rdi_msg_err      = msg_err;
    assign o_rdi_busy         = ~fifo_empty | o_rdi_header_valid;

endmodule
